pe_feeder: RTL and testbench

Job sequencer that drives one 9-cell processing element (PE) and collects its saturated results. It accepts a job descriptor, then buffers all of the job's 9-cell input/weight chunks. Once every chunk is held, it issues them to the PE on back-to-back cycles, with step, bound level and bias held constant. It captures each PE result into a 2-entry result FIFO with valid/ready output. It exists because the PE has no backpressure and corrupts its accumulation if `en` drops mid-job.

---
 rtl/pe_feeder.sv | 183 ++++++++++++++++++
 tb/tb_pe_feeder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Sequences one job into a 9-cell PE: latch descriptor, buffer all chunks, then burst them out gap-free.
// Latency: last chunk accepted at edge L -> pe_en high L+1..L+S+1 (if credit); result visible 1 cycle after PE strobe.
// Backpressure: cfg/dat valid-ready; a burst only starts when the 2-entry result FIFO can absorb its result.
module pe_feeder #(
  parameter int CELL_BIT = 8,
  parameter int N_CELL   = 9,
  parameter int BIAS_W   = 16,
  parameter int OUT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [2:0]                   cfg_step,
  input  logic [2:0]                   cfg_bound,
  input  logic [BIAS_W-1:0]            cfg_bias,
  input  logic                         dat_valid,
  output logic                         dat_ready,
  input  logic [CELL_BIT*N_CELL-1:0]   dat_in,
  input  logic [CELL_BIT*N_CELL-1:0]   dat_w,
  output logic [CELL_BIT*N_CELL-1:0]   pe_in,
  output logic [CELL_BIT*N_CELL-1:0]   pe_weight,
  output logic [BIAS_W-1:0]            pe_bias,
  output logic [2:0]                   pe_bound_level,
  output logic [2:0]                   pe_step,
  output logic                         pe_en,
  input  logic [OUT_W-1:0]             pe_out,
  input  logic                         pe_out_en,
  output logic                         res_valid,
  output logic [OUT_W-1:0]             res_data,
  input  logic                         res_ready,
  output logic                         busy,
  output logic                         err
);

  localparam int CW = CELL_BIT * N_CELL;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, BURST} state_t;

  state_t            state;
  logic [2:0]        step_q;
  logic [2:0]        bound_q;
  logic [BIAS_W-1:0] bias_q;
  logic [2:0]        k;
  logic [2:0]        j;
  logic [2*CW-1:0]   buffer [8];

  logic [1:0]        inflight;
  logic [1:0]        fifo_count;
  logic [OUT_W-1:0]  fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;

  logic              dat_fire;
  logic              last_chunk;
  logic              credit;
  logic              start_burst;
  logic [2*CW-1:0]   first_chunk;
  logic              ret;
  logic              push;
  logic              pop;
  logic              strobe_err;

  // Handshake decode, credit check and burst-start decision.
  always_comb begin
    dat_fire    = (state == LOAD) && dat_valid;
    last_chunk  = dat_fire && (k == step_q);
    credit      = ({1'b0, fifo_count} + {1'b0, inflight}) < 3'd2;
    start_burst = credit && (last_chunk || (state == WAIT));
    // A single-chunk job leaves LOAD on the same edge its only chunk is written, so bypass the buffer.
    first_chunk = ((state == LOAD) && (step_q == 3'd0)) ? {dat_in, dat_w} : buffer[0];
    ret         = pe_out_en && (inflight != 2'd0);
    push        = ret && (fifo_count != 2'd2);
    pop         = res_valid && res_ready;
    strobe_err  = pe_out_en && ((inflight == 2'd0) || (fifo_count == 2'd2));
  end

  assign cfg_ready = (state == IDLE);
  assign dat_ready = (state == LOAD);
  assign res_valid = (fifo_count != 2'd0);
  assign res_data  = fifo_mem[rd_ptr];
  assign busy      = (state != IDLE) || (inflight != 2'd0);

  // Chunk buffer: written in arrival order, index k.
  always_ff @(posedge clk) begin
    if (dat_fire) begin
      buffer[k] <= {dat_in, dat_w};
    end
  end

  // Job FSM and registered PE drive; PE-side fields only change while a burst is issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      step_q         <= 3'd0;
      bound_q        <= 3'd0;
      bias_q         <= '0;
      k              <= 3'd0;
      j              <= 3'd0;
      pe_en          <= 1'b0;
      pe_in          <= '0;
      pe_weight      <= '0;
      pe_bias        <= '0;
      pe_step        <= 3'd0;
      pe_bound_level <= 3'd0;
    end else begin
      pe_en <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            step_q  <= cfg_step;
            bound_q <= cfg_bound;
            bias_q  <= cfg_bias;
            k       <= 3'd0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (dat_valid) begin
            k <= k + 3'd1;
            if (k == step_q) begin
              state <= credit ? BURST : WAIT;
            end
          end
        end
        WAIT: begin
          if (credit) begin
            state <= BURST;
          end
        end
        BURST: begin
          // j is the chunk currently presented to the PE.
          if (j == step_q) begin
            state <= IDLE;
          end else begin
            j                  <= j + 3'd1;
            pe_en              <= 1'b1;
            {pe_in, pe_weight} <= buffer[j + 3'd1];
          end
        end
      endcase
      if (start_burst) begin
        pe_en              <= 1'b1;
        {pe_in, pe_weight} <= first_chunk;
        pe_bias            <= bias_q;
        pe_step            <= step_q;
        pe_bound_level     <= bound_q;
        j                  <= 3'd0;
      end
    end
  end

  // Inflight job count, result FIFO and sticky protocol error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight    <= 2'd0;
      fifo_count  <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      err         <= 1'b0;
    end else begin
      inflight <= inflight + {1'b0, start_burst} - {1'b0, ret};
      if (push) begin
        fifo_mem[wr_ptr] <= pe_out;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (strobe_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: directed job sequence with random cell data, a behavioural PE on the far side,
// and a job-level model (chunk list + expected saturated result per job) to check issue order and results.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_step;
  logic [2:0]  cfg_bound;
  logic [15:0] cfg_bias;
  logic        dat_valid;
  logic        dat_ready;
  logic [71:0] dat_in;
  logic [71:0] dat_w;
  logic [71:0] pe_in;
  logic [71:0] pe_weight;
  logic [15:0] pe_bias;
  logic [2:0]  pe_bound_level;
  logic [2:0]  pe_step;
  logic        pe_en;
  logic [7:0]  pe_out;
  logic        pe_out_en;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_ready;
  logic        busy;
  logic        err;

  pe_feeder dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_step(cfg_step),
    .cfg_bound(cfg_bound), .cfg_bias(cfg_bias),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in), .dat_w(dat_w),
    .pe_in(pe_in), .pe_weight(pe_weight), .pe_bias(pe_bias),
    .pe_bound_level(pe_bound_level), .pe_step(pe_step), .pe_en(pe_en),
    .pe_out(pe_out), .pe_out_en(pe_out_en),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] in_c;
    logic [71:0] w_c;
    logic [2:0]  step;
    logic [2:0]  bound;
    logic [15:0] bias;
    int          cyc;
  } rec_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         last_acc;
  int         gap [8];
  rec_t       got_q [$];
  rec_t       exp_q [$];
  logic [7:0] exp_res [$];

  function automatic int dot(input logic [71:0] a, input logic [71:0] b);
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
    return s;
  endfunction

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'hFF : v[7:0];
  endfunction

  // Behavioural PE: accumulates dot products while en is high, strobes the saturated
  // sum plus bias high byte 2 cycles after the last en cycle. Shares the reset.
  logic       prev_en = 1'b0;
  int         acc     = 0;
  logic       strobe_m = 1'b0;
  logic [7:0] out_m    = 8'h00;
  logic       spur     = 1'b0;
  logic [7:0] spur_val = 8'h00;

  assign pe_out_en = strobe_m | spur;
  assign pe_out    = spur ? spur_val : out_m;

  always @(posedge clk) begin
    rec_t r;
    cyc      <= cyc + 1;
    strobe_m <= 1'b0;
    if (!reset) begin
      prev_en <= 1'b0;
      acc     <= 0;
    end else begin
      prev_en <= pe_en;
      if (pe_en) begin
        acc     <= acc + dot(pe_in, pe_weight);
        r.in_c  = pe_in;
        r.w_c   = pe_weight;
        r.step  = pe_step;
        r.bound = pe_bound_level;
        r.bias  = pe_bias;
        r.cyc   = cyc;
        got_q.push_back(r);
      end else if (prev_en) begin
        strobe_m <= 1'b1;
        out_m    <= sat8(acc + int'(pe_bias[15:8]));
        acc      <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic [2:0] s, input logic [2:0] b, input logic [15:0] bs);
    int n = 0;
    cfg_step = s; cfg_bound = b; cfg_bias = bs; cfg_valid = 1'b1;
    while (!cfg_ready && n < 200) begin @(negedge clk); n++; end
    chk("cfg_accept", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_chunk(input logic [71:0] di, input logic [71:0] dw, input int g);
    int n = 0;
    dat_valid = 1'b0;
    repeat (g) @(negedge clk);
    dat_in = di; dat_w = dw; dat_valid = 1'b1;
    while (!dat_ready && n < 200) begin @(negedge clk); n++; end
    chk("dat_accept", dat_ready, 1);
    @(negedge clk);
    dat_valid = 1'b0;
  endtask

  // Sends one job; records its chunks and its expected result in the job-level model.
  task automatic run_job(input int s, input logic [2:0] bnd, input logic [15:0] bs, input bit ones);
    rec_t c;
    int   sum = 0;
    send_cfg(s[2:0], bnd, bs);
    for (int i = 0; i <= s; i++) begin
      for (int b = 0; b < 9; b++) begin
        c.in_c[8*b +: 8] = ones ? 8'd1 : 8'($urandom_range(0, 3));
        c.w_c[8*b +: 8]  = ones ? 8'd1 : 8'($urandom_range(0, 3));
      end
      c.step = s[2:0]; c.bound = bnd; c.bias = bs; c.cyc = 0;
      sum += dot(c.in_c, c.w_c);
      exp_q.push_back(c);
      send_chunk(c.in_c, c.w_c, gap[i]);
    end
    exp_res.push_back(sat8(sum + int'(bs[15:8])));
    last_acc = cyc;
  endtask

  task automatic wait_issued(input int n);
    int t = 0;
    while (got_q.size() < n && t < 200) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("issue_count", got_q.size(), n);
  endtask

  // Compares issued chunks against the model; with timing, also requires a gap-free
  // burst starting the cycle after the last chunk was accepted.
  task automatic check_issue(input bit timing);
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    chk("issue_len", got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      chk("pe_in",    got_q[i].in_c,  exp_q[i].in_c);
      chk("pe_weight", got_q[i].w_c,  exp_q[i].w_c);
      chk("pe_step",  got_q[i].step,  exp_q[i].step);
      chk("pe_bound", got_q[i].bound, exp_q[i].bound);
      chk("pe_bias",  got_q[i].bias,  exp_q[i].bias);
      if (timing) chk("pe_en_cycle", got_q[i].cyc, last_acc + i);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pop_one();
    int t = 0;
    while (!res_valid && t < 200) begin @(negedge clk); t++; end
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, (exp_res.size() > 0) ? exp_res.pop_front() : 8'hXX);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; cfg_step = 3'd0; cfg_bound = 3'd0; cfg_bias = 16'h0;
    dat_valid = 1'b0; dat_in = '0; dat_w = '0; res_ready = 1'b0;
    for (int i = 0; i < 8; i++) gap[i] = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_dat_ready", dat_ready, 0);
    chk("rst_pe_en", pe_en, 0);
    chk("rst_pe_in", pe_in, 0);
    chk("rst_pe_bias", pe_bias, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single-chunk job of all ones: 9 + 5 = 0x0E
    run_job(0, 3'd0, 16'h0500, 1'b1);
    chk("job1_busy", busy, 1);
    wait_issued(1);
    check_issue(1'b1);
    chk("job1_exp", exp_res[0], 8'h0E);
    pop_one();
    chk("job1_idle", busy, 0);
    chk("job1_empty", res_valid, 0);

    // Three chunks with gaps in dat_valid: 1,0,0,1,0,1
    gap[0] = 0; gap[1] = 2; gap[2] = 1;
    run_job(2, 3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) gap[i] = 0;
    wait_issued(3);
    check_issue(1'b1);
    pop_one();

    // Result FIFO full: third job waits for credit
    run_job(0, 3'd1, 16'($urandom), 1'b0);
    run_job(0, 3'd2, 16'($urandom), 1'b0);
    run_job(0, 3'd3, 16'($urandom), 1'b0);
    repeat (10) @(negedge clk);
    chk("wait_hold_issued", got_q.size(), 2);
    chk("wait_hold_busy", busy, 1);
    chk("wait_hold_cfg_ready", cfg_ready, 0);
    pop_one();
    wait_issued(3);
    check_issue(1'b0);
    pop_one();
    pop_one();
    chk("fifo_err", err, 0);

    // Full eight-chunk job
    run_job(7, 3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
    wait_issued(8);
    check_issue(1'b1);
    pop_one();

    // Random jobs with random gaps
    for (int r = 0; r < 4; r++) begin
      int s = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) gap[i] = $urandom_range(0, 2);
      run_job(s, 3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
      wait_issued(s + 1);
      check_issue(1'b1);
      pop_one();
    end
    for (int i = 0; i < 8; i++) gap[i] = 0;

    // Reset on the 2nd burst cycle of a 4-chunk job abandons it
    run_job(3, 3'd5, 16'($urandom), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_pe_en", pe_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    reset = 1'b1;
    void'(exp_res.pop_back());
    got_q.delete();
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("midrst_no_result", res_valid, 0);
    run_job(1, 3'd2, 16'($urandom), 1'b0);
    wait_issued(2);
    check_issue(1'b1);
    pop_one();
    chk("post_rst_busy", busy, 0);

    // Stray PE strobe with nothing in flight
    spur_val = 8'($urandom);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("stray_err", err, 1);
    chk("stray_fifo", res_valid, 0);
    repeat (5) @(negedge clk);
    chk("stray_err_sticky", err, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
